// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - shared constants for the decode-stage interlock controller
package id_hazard_ctrl_pkg;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MDU  = 2'b10,
    CLS_RSV  = 2'b11
  } id_class_e;

  localparam logic RST_ACTIVE   = 1'b0;
  localparam int   LOAD_LAT_DEF = 1;
  localparam int   MDU_LAT_DEF  = 32;
endpackage

// File: rtl/id_hazard_ctrl_sb_cnt_cell.sv
// rtl/id_hazard_ctrl_sb_cnt_cell.sv - one scoreboard countdown entry
module sb_cnt_cell
  import id_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             nonzero
);
  logic [CNT_W-1:0] cnt;

  // A fresh issue wins over the countdown of the same entry.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign nonzero = (cnt != '0);
endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - decode-stage RAW/WAW/MDU interlock and pipeline stall vector
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 6,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MDU_LAT  = MDU_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid_i,
  input  logic               id_reg1_read_i,
  input  logic [REG_AW-1:0]  id_reg1_addr_i,
  input  logic               id_reg2_read_i,
  input  logic [REG_AW-1:0]  id_reg2_addr_i,
  input  logic               id_wreg_i,
  input  logic [REG_AW-1:0]  id_wd_i,
  input  logic [1:0]         id_class_i,
  input  logic               stallreq_ex_i,
  input  logic               flush_i,
  output logic [5:0]         stall_o,
  output logic               stallreq_id_o,
  output logic               mdu_busy_o,
  output logic [REG_NUM-1:0] pending_o
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MDU_VAL  = CNT_W'(MDU_LAT);

  logic               run;
  logic [REG_NUM-1:0] pend;
  logic               mdu_nz;
  logic               is_load, is_mdu;
  logic               raw1, raw2, waw, structural;
  logic               issue, issue_rec, dec_en;
  logic [5:0]         stall;

  assign run     = (rst != RST_ACTIVE);
  assign is_load = (id_class_i == CLS_LOAD);
  assign is_mdu  = (id_class_i == CLS_MDU);
  assign dec_en  = !stallreq_ex_i;

  // Register 0 has no cell, so it can never be pending.
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
    sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .load     (issue_rec && (id_wd_i == REG_AW'(r))),
      .load_val (is_mdu ? MDU_VAL : LOAD_VAL),
      .dec      (dec_en),
      .nonzero  (pend[r])
    );
  end

  sb_cnt_cell #(.CNT_W(CNT_W)) u_mdu_cell (
    .clk      (clk),
    .rst      (rst),
    .load     (issue && is_mdu),
    .load_val (MDU_VAL),
    .dec      (dec_en),
    .nonzero  (mdu_nz)
  );

  assign raw1       = id_reg1_read_i && (id_reg1_addr_i != '0) && pend[id_reg1_addr_i];
  assign raw2       = id_reg2_read_i && (id_reg2_addr_i != '0) && pend[id_reg2_addr_i];
  assign waw        = id_wreg_i && (id_wd_i != '0) && pend[id_wd_i];
  assign structural = is_mdu && mdu_nz;

  assign stallreq_id_o = run && id_valid_i && !flush_i && (raw1 || raw2 || waw || structural);

  // The execute hold outranks the decode hold and is not masked by flush.
  always_comb begin
    stall = 6'b000000;
    if (run && stallreq_ex_i)
      stall = 6'b001111;
    else if (stallreq_id_o)
      stall = 6'b000111;
  end

  assign issue     = id_valid_i && !flush_i && !stall[STALL_ID] && id_wreg_i && (id_wd_i != '0);
  assign issue_rec = issue && (is_load || is_mdu);

  assign stall_o    = stall;
  assign mdu_busy_o = run && mdu_nz;
  assign pending_o  = run ? pend : '0;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - scoreboard bench for the decode-stage interlock controller
module tb_id_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        id_reg1_read_i = 1'b0;
  logic [4:0]  id_reg1_addr_i = '0;
  logic        id_reg2_read_i = 1'b0;
  logic [4:0]  id_reg2_addr_i = '0;
  logic        id_wreg_i = 1'b0;
  logic [4:0]  id_wd_i = '0;
  logic [1:0]  id_class_i = '0;
  logic        stallreq_ex_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [5:0]  stall_o;
  logic        stallreq_id_o;
  logic        mdu_busy_o;
  logic [31:0] pending_o;

  localparam logic [1:0]  ALU = 2'b00, LD = 2'b01, MDU = 2'b10;
  localparam logic [5:0]  S0 = 6'b000000, S_ID = 6'b000111, S_EX = 6'b001111;
  localparam logic [31:0] P0 = 32'h0, P3 = 32'h8, P5 = 32'h20, P8 = 32'h100, P10 = 32'h400;

  logic [39:0] exp_q[$];
  string       tag_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  id_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_wreg_i      (id_wreg_i),
    .id_wd_i        (id_wd_i),
    .id_class_i     (id_class_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .stallreq_id_o  (stallreq_id_o),
    .mdu_busy_o     (mdu_busy_o),
    .pending_o      (pending_o)
  );

  always #5 clk = ~clk;

  // One decode cycle: drive just after the rising edge, queue the expected response.
  task automatic step(input string tag, input logic rv, input logic v,
                      input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                      input logic w, input logic [4:0] wd, input logic [1:0] cls,
                      input logic ex, input logic fl,
                      input logic [5:0] es, input logic esid, input logic eb, input logic [31:0] ep);
    @(posedge clk);
    #1;
    rst = rv; id_valid_i = v;
    id_reg1_read_i = r1; id_reg1_addr_i = a1;
    id_reg2_read_i = r2; id_reg2_addr_i = a2;
    id_wreg_i = w; id_wd_i = wd; id_class_i = cls;
    stallreq_ex_i = ex; flush_i = fl;
    exp_q.push_back({es, esid, eb, ep});
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [39:0] e;
      logic [39:0] a;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {stall_o, stallreq_id_o, mdu_busy_o, pending_o};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got stall=%b sid=%b busy=%b pend=%h, want stall=%b sid=%b busy=%b pend=%h",
                 t, a[39:34], a[33], a[32], a[31:0], e[39:34], e[33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    // reset: a load presented during reset leaves no entry behind
    step("rst_a",   0, 1, 0, 0, 0, 0, 1, 5, LD,  0, 0, S0, 0, 0, P0);
    step("rst_b",   1, 1, 1, 5, 0, 0, 1, 6, ALU, 0, 0, S0, 0, 0, P0);
    // load-use on rs
    step("lu_issue",1, 1, 0, 0, 0, 0, 1, 5, LD,  0, 0, S0, 0, 0, P0);
    step("lu_stall",1, 1, 1, 5, 0, 0, 1, 6, ALU, 0, 0, S_ID, 1, 0, P5);
    step("lu_go",   1, 1, 1, 5, 0, 0, 1, 6, ALU, 0, 0, S0, 0, 0, P0);
    // WAW
    step("waw_iss", 1, 1, 0, 0, 0, 0, 1, 5, LD,  0, 0, S0, 0, 0, P0);
    step("waw_stl", 1, 1, 0, 0, 0, 0, 1, 5, ALU, 0, 0, S_ID, 1, 0, P5);
    step("waw_go",  1, 1, 0, 0, 0, 0, 1, 5, ALU, 0, 0, S0, 0, 0, P0);
    // load-use on rt
    step("rt_iss",  1, 1, 0, 0, 0, 0, 1, 3, LD,  0, 0, S0, 0, 0, P0);
    step("rt_stl",  1, 1, 0, 0, 1, 3, 0, 0, ALU, 0, 0, S_ID, 1, 0, P3);
    step("rt_go",   1, 1, 0, 0, 1, 3, 0, 0, ALU, 0, 0, S0, 0, 0, P0);
    // register 0
    step("r0_load", 1, 1, 0, 0, 0, 0, 1, 0, LD,  0, 0, S0, 0, 0, P0);
    step("r0_read", 1, 1, 1, 0, 1, 0, 1, 0, LD,  0, 0, S0, 0, 0, P0);
    // MDU RAW: 32 stall cycles
    step("mdu_iss", 1, 1, 0, 0, 0, 0, 1, 8, MDU, 0, 0, S0, 0, 0, P0);
    for (int k = 0; k < 32; k++)
      step("mdu_raw", 1, 1, 1, 8, 0, 0, 1, 9, ALU, 0, 0, S_ID, 1, 1, P8);
    step("mdu_go",  1, 1, 1, 8, 0, 0, 1, 9, ALU, 0, 0, S0, 0, 0, P0);
    // second MDU op blocked on busy MDU
    step("mdu2_iss",1, 1, 0, 0, 0, 0, 1, 8, MDU, 0, 0, S0, 0, 0, P0);
    for (int k = 0; k < 32; k++)
      step("mdu_str", 1, 1, 0, 0, 0, 0, 1, 10, MDU, 0, 0, S_ID, 1, 1, P8);
    step("mdu_str_go", 1, 1, 0, 0, 0, 0, 1, 10, MDU, 0, 0, S0, 0, 0, P0);
    // EX hold freezes the countdown: reader of r10 then waits the full 32
    for (int k = 0; k < 3; k++)
      step("ex_hold", 1, 1, 1, 10, 0, 0, 1, 11, ALU, 1, 0, S_EX, 1, 1, P10);
    for (int k = 0; k < 32; k++)
      step("ex_raw",  1, 1, 1, 10, 0, 0, 1, 11, ALU, 0, 0, S_ID, 1, 1, P10);
    step("ex_go",   1, 1, 1, 10, 0, 0, 1, 11, ALU, 0, 0, S0, 0, 0, P0);
    // flush squashes both the hazard and the scoreboard entry
    step("fl_iss",  1, 1, 0, 0, 0, 0, 1, 5, LD,  0, 0, S0, 0, 0, P0);
    step("fl_hz",   1, 1, 1, 5, 0, 0, 1, 7, LD,  0, 1, S0, 0, 0, P5);
    step("fl_chk",  1, 1, 1, 7, 0, 0, 0, 0, ALU, 0, 0, S0, 0, 0, P0);
    // flush does not mask the EX hold
    step("flx_iss", 1, 1, 0, 0, 0, 0, 1, 5, LD,  0, 0, S0, 0, 0, P0);
    step("flx_ex",  1, 1, 1, 5, 0, 0, 1, 6, ALU, 1, 1, S_EX, 0, 0, P5);
    step("flx_stl", 1, 1, 1, 5, 0, 0, 1, 6, ALU, 0, 0, S_ID, 1, 0, P5);
    step("flx_go",  1, 1, 1, 5, 0, 0, 1, 6, ALU, 0, 0, S0, 0, 0, P0);
    // reset mid-operation with cnt[8] == 20
    step("rm_iss",  1, 1, 0, 0, 0, 0, 1, 8, MDU, 0, 0, S0, 0, 0, P0);
    for (int k = 0; k < 12; k++)
      step("rm_wait", 1, 0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, S0, 0, 1, P8);
    step("rm_rst",  0, 1, 1, 8, 0, 0, 1, 9, ALU, 0, 0, S0, 0, 0, P0);
    step("rm_read", 1, 1, 1, 8, 0, 0, 1, 9, ALU, 0, 0, S0, 0, 0, P0);

    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
